// File: rtl/iir_sched_pkg.sv
// Shared types and sizing helpers for the time-multiplexed biquad cascade.
package iir_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [2:0] SEL_B0 = 3'd0;
  localparam logic [2:0] SEL_B1 = 3'd1;
  localparam logic [2:0] SEL_B2 = 3'd2;
  localparam logic [2:0] SEL_A1 = 3'd3;
  localparam logic [2:0] SEL_A2 = 3'd4;
  localparam int NUM_TAPS = 5;

  // Four guard bits cover the sum of five full-scale products.
  function automatic int acc_width(input int dw, input int cw);
    return dw + cw + 4;
  endfunction

  function automatic int sat_max(input int dw);
    return (1 << (dw - 1)) - 1;
  endfunction

  function automatic int sat_min(input int dw);
    return -(1 << (dw - 1));
  endfunction

endpackage

// File: rtl/iir_mac_unit.sv
// Shared multiply-accumulate: one signed product per enabled cycle, floor-shift and saturate on output.
module iir_mac_unit
  import iir_sched_pkg::*;
#(
  parameter int DW   = 12,
  parameter int CW   = 14,
  parameter int FRAC = 11
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 sub,
  input  logic signed [DW-1:0] din,
  input  logic signed [CW-1:0] coef,
  output logic signed [DW-1:0] y
);

  localparam int PW = DW + CW;
  localparam int AW = acc_width(DW, CW);
  localparam logic signed [AW-1:0] YMAX = AW'(sat_max(DW));
  localparam logic signed [AW-1:0] YMIN = AW'(sat_min(DW));

  logic signed [PW-1:0] prod_p0;
  logic signed [AW-1:0] prod_ext_p0;
  logic signed [AW-1:0] acc_p1;

  function automatic logic signed [DW-1:0] shift_sat(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] s;
    s = a >>> FRAC;
    if (s > YMAX) s = YMAX;
    else if (s < YMIN) s = YMIN;
    return s[DW-1:0];
  endfunction

  assign prod_p0     = PW'(din) * PW'(coef);
  assign prod_ext_p0 = AW'(prod_p0);

  // p0 -> p1: accumulate (first product of a stage is loaded, not added)
  always_ff @(posedge clk) begin
    if (en) begin
      if (clr) acc_p1 <= sub ? -prod_ext_p0 : prod_ext_p0;
      else     acc_p1 <= sub ? acc_p1 - prod_ext_p0 : acc_p1 + prod_ext_p0;
    end
  end

  assign y = shift_sat(acc_p1);

endmodule

// File: rtl/iir_cascade_scheduler.sv
// Biquad cascade evaluated on one shared MAC: five products then a write-back per stage.
module iir_cascade_scheduler
  import iir_sched_pkg::*;
#(
  parameter int N_STAGES = 4,
  parameter int DW       = 12,
  parameter int CW       = 14,
  parameter int FRAC     = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_data,
  output logic                 busy,
  input  logic                 cfg_we,
  input  logic [2:0]           cfg_stage,
  input  logic [2:0]           cfg_sel,
  input  logic signed [CW-1:0] cfg_data,
  output logic                 cfg_err,
  input  logic                 clr_state
);

  localparam int SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam logic signed [CW-1:0] UNITY = CW'(1 << FRAC);

  state_t state_q, state_d;
  logic [2:0]    k;
  logic [SW-1:0] s;
  logic          accept, last, mac_en, wb, cfg_ok;

  logic signed [CW-1:0] coef [N_STAGES][NUM_TAPS];
  logic signed [DW-1:0] x1 [N_STAGES];
  logic signed [DW-1:0] x2 [N_STAGES];
  logic signed [DW-1:0] y1 [N_STAGES];
  logic signed [DW-1:0] y2 [N_STAGES];
  logic signed [DW-1:0] sample_p0, stage_x, din, mac_y;
  logic signed [CW-1:0] coef_op;

  assign in_ready = (state_q == IDLE) && !rst;
  assign busy     = (state_q != IDLE);
  assign accept   = in_valid && in_ready;
  assign last     = (s == SW'(N_STAGES - 1));
  assign cfg_ok   = (int'(cfg_stage) < N_STAGES) && (cfg_sel <= SEL_A2);

  always_comb begin
    state_d = state_q;
    mac_en  = 1'b0;
    wb      = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = MAC;
      MAC: begin
        mac_en = 1'b1;
        if (k == 3'd4) state_d = WB;
      end
      WB: begin
        wb      = 1'b1;
        state_d = last ? IDLE : MAC;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      k         <= '0;
      s         <= '0;
      out_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      k         <= (state_q == MAC) ? k + 3'd1 : 3'd0;
      if (state_q == IDLE) s <= '0;
      else if (wb)         s <= last ? '0 : s + SW'(1);
      out_valid <= wb && last;
      cfg_err   <= cfg_we && ((state_q != IDLE) || !cfg_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) sample_p0 <= in_data;
  end

  // Stage 0 reads the captured sample; later stages read the previous stage's fresh y1.
  assign stage_x = (s == '0) ? sample_p0 : y1[s - SW'(1)];

  always_comb begin
    din = stage_x;
    case (k)
      SEL_B1:  din = x1[s];
      SEL_B2:  din = x2[s];
      SEL_A1:  din = y1[s];
      SEL_A2:  din = y2[s];
      default: din = stage_x;
    endcase
  end

  assign coef_op = coef[s][k];

  iir_mac_unit #(.DW(DW), .CW(CW), .FRAC(FRAC)) u_mac (
    .clk  (clk),
    .en   (mac_en),
    .clr  (k == SEL_B0),
    .sub  (k == SEL_A2),
    .din  (din),
    .coef (coef_op),
    .y    (mac_y)
  );

  // p1 -> p2: stage write-back, coefficient and delay-line updates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      for (int i = 0; i < N_STAGES; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
        for (int j = 0; j < NUM_TAPS; j++) coef[i][j] <= (j == 0) ? UNITY : '0;
      end
    end else begin
      if (state_q == IDLE && cfg_we && cfg_ok)
        coef[cfg_stage[SW-1:0]][cfg_sel] <= cfg_data;
      if (state_q == IDLE && clr_state) begin
        for (int i = 0; i < N_STAGES; i++) begin
          x1[i] <= '0;
          x2[i] <= '0;
          y1[i] <= '0;
          y2[i] <= '0;
        end
      end
      if (wb) begin
        x2[s] <= x1[s];
        x1[s] <= stage_x;
        y2[s] <= y1[s];
        y1[s] <= mac_y;
        if (last) out_data <= mac_y;
      end
    end
  end

endmodule

// File: tb/tb_iir_cascade_scheduler.sv
// Directed bench for iir_cascade_scheduler with hand-computed responses.
module tb_iir_cascade_scheduler;

  localparam int N   = 4;
  localparam int DW  = 12;
  localparam int CW  = 14;
  localparam int LAT = 6 * N;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic signed [DW-1:0] out_data;
  logic                 busy;
  logic                 cfg_we;
  logic [2:0]           cfg_stage;
  logic [2:0]           cfg_sel;
  logic signed [CW-1:0] cfg_data;
  logic                 cfg_err;
  logic                 clr_state;

  int n_tests = 0;
  int n_fail  = 0;

  iir_cascade_scheduler #(.N_STAGES(N), .DW(DW), .CW(CW), .FRAC(11)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .cfg_we    (cfg_we),
    .cfg_stage (cfg_stage),
    .cfg_sel   (cfg_sel),
    .cfg_data  (cfg_data),
    .cfg_err   (cfg_err),
    .clr_state (clr_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic send(input logic signed [DW-1:0] x, output logic signed [DW-1:0] y, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      tick();
      w++;
    end
    in_data  = x;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = -1;
    y   = '0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (out_valid) begin
        lat = c;
        y   = out_data;
        break;
      end
    end
  endtask

  task automatic cfg_write(input int stage, input int sel, input int data, output logic err);
    cfg_stage = 3'(stage);
    cfg_sel   = 3'(sel);
    cfg_data  = CW'(data);
    cfg_we    = 1'b1;
    tick();
    cfg_we = 1'b0;
    err    = cfg_err;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %0b expected 0", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b expected 0", out_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b expected 0", busy); end
    n_tests++; if (out_data !== 12'sd0) begin n_fail++; $display("FAIL reset_out_data got %0d expected 0", out_data); end
    n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err got %0b expected 0", cfg_err); end
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %0b expected 1", in_ready); end
  endtask

  task automatic test_impulse();
    logic signed [DW-1:0] y;
    int lat;
    int exp_y [3] = '{1000, 0, 0};
    int xs    [3] = '{1000, 0, 0};
    for (int i = 0; i < 3; i++) begin
      send(DW'(xs[i]), y, lat);
      n_tests++; if (y !== DW'(exp_y[i])) begin n_fail++; $display("FAIL impulse_y[%0d] got %0d expected %0d", i, y, exp_y[i]); end
      n_tests++; if (lat != LAT) begin n_fail++; $display("FAIL impulse_latency[%0d] got %0d expected %0d", i, lat, LAT); end
    end
  endtask

  task automatic test_biquad();
    logic signed [DW-1:0] y;
    logic err, any_err;
    int lat;
    int cf    [5] = '{94, 140, 94, 1213, 268};
    int exp_y [4] = '{45, 95, 96, 44};
    do_reset();
    any_err = 1'b0;
    for (int j = 0; j < 5; j++) begin
      cfg_write(0, j, cf[j], err);
      any_err |= err;
    end
    n_tests++; if (any_err !== 1'b0) begin n_fail++; $display("FAIL biquad_cfg_err got %0b expected 0", any_err); end
    for (int i = 0; i < 4; i++) begin
      send((i == 0) ? 12'sd1000 : 12'sd0, y, lat);
      n_tests++; if (y !== DW'(exp_y[i])) begin n_fail++; $display("FAIL biquad_y[%0d] got %0d expected %0d", i, y, exp_y[i]); end
    end
    clr_state = 1'b1;
    tick();
    clr_state = 1'b0;
    send(12'sd0, y, lat);
    n_tests++; if (y !== 12'sd0) begin n_fail++; $display("FAIL clr_state_zero got %0d expected 0", y); end
    send(12'sd1000, y, lat);
    n_tests++; if (y !== 12'sd45) begin n_fail++; $display("FAIL clr_state_restart got %0d expected 45", y); end
  endtask

  task automatic test_saturation();
    logic signed [DW-1:0] y;
    logic err;
    int lat;
    do_reset();
    cfg_write(0, 0, 8191, err);
    send(12'sd2047, y, lat);
    n_tests++; if (y !== 12'sd2047) begin n_fail++; $display("FAIL sat_pos got %0d expected 2047", y); end
    send(-12'sd2048, y, lat);
    n_tests++; if (y !== -12'sd2048) begin n_fail++; $display("FAIL sat_neg got %0d expected -2048", y); end
  endtask

  task automatic test_cfg_errors();
    logic signed [DW-1:0] y;
    logic err;
    int lat, w;
    do_reset();
    cfg_write(0, 5, 100, err);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL cfg_bad_sel got %0b expected 1", err); end
    tick();
    n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_err_pulse got %0b expected 0", cfg_err); end
    cfg_write(4, 0, 100, err);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL cfg_bad_stage got %0b expected 1", err); end
    in_data  = 12'sd1000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    cfg_write(3, 0, 0, err);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL cfg_busy_err got %0b expected 1", err); end
    y = '0;
    w = 0;
    while (!out_valid && w < 40) begin
      tick();
      w++;
    end
    if (out_valid) y = out_data;
    n_tests++; if (y !== 12'sd1000) begin n_fail++; $display("FAIL cfg_busy_ignored got %0d expected 1000", y); end
    send(12'sd1000, y, lat);
    n_tests++; if (y !== 12'sd1000) begin n_fail++; $display("FAIL cfg_busy_unchanged got %0d expected 1000", y); end
    // Write and accept in the same idle cycle: stage 3 gain 2 applies to this sample.
    cfg_stage = 3'd3;
    cfg_sel   = 3'd0;
    cfg_data  = 14'sd4096;
    cfg_we    = 1'b1;
    in_data   = 12'sd100;
    in_valid  = 1'b1;
    tick();
    cfg_we   = 1'b0;
    in_valid = 1'b0;
    n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_with_accept_err got %0b expected 0", cfg_err); end
    y = '0;
    w = 0;
    while (!out_valid && w < 40) begin
      tick();
      w++;
    end
    if (out_valid) y = out_data;
    n_tests++; if (y !== 12'sd200) begin n_fail++; $display("FAIL cfg_with_accept_y got %0d expected 200", y); end
  endtask

  task automatic test_back_to_back();
    int acc_cyc [$];
    int viol, n_out, w;
    do_reset();
    viol     = 0;
    n_out    = 0;
    in_data  = 12'sd5;
    in_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (in_valid && in_ready) acc_cyc.push_back(c);
      if (busy && in_ready) viol++;
      tick();
      if (out_valid) n_out++;
    end
    in_valid = 1'b0;
    n_tests++; if (acc_cyc.size() != 3) begin n_fail++; $display("FAIL b2b_accepts got %0d expected 3", acc_cyc.size()); end
    if (acc_cyc.size() == 3) begin
      n_tests++; if (acc_cyc[1] - acc_cyc[0] != LAT + 1) begin n_fail++; $display("FAIL b2b_spacing0 got %0d expected %0d", acc_cyc[1] - acc_cyc[0], LAT + 1); end
      n_tests++; if (acc_cyc[2] - acc_cyc[1] != LAT + 1) begin n_fail++; $display("FAIL b2b_spacing1 got %0d expected %0d", acc_cyc[2] - acc_cyc[1], LAT + 1); end
    end
    n_tests++; if (viol != 0) begin n_fail++; $display("FAIL b2b_ready_while_busy got %0d expected 0", viol); end
    n_tests++; if (n_out != 2) begin n_fail++; $display("FAIL b2b_outputs got %0d expected 2", n_out); end
    w = 0;
    while (!in_ready && w < 40) begin
      tick();
      w++;
    end
    n_tests++; if (out_data !== 12'sd5) begin n_fail++; $display("FAIL b2b_out_data got %0d expected 5", out_data); end
  endtask

  task automatic test_reset_mid();
    logic signed [DW-1:0] y;
    logic err;
    int lat, n_out;
    do_reset();
    cfg_write(0, 0, 500, err);
    in_data  = 12'sd1000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    rst = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready got %0b expected 0", in_ready); end
    tick();
    tick();
    rst   = 1'b0;
    n_out = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (out_valid) n_out++;
    end
    n_tests++; if (n_out != 0) begin n_fail++; $display("FAIL midrst_no_output got %0d expected 0", n_out); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %0b expected 1", in_ready); end
    send(12'sd1000, y, lat);
    n_tests++; if (y !== 12'sd1000) begin n_fail++; $display("FAIL midrst_passthrough got %0d expected 1000", y); end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    cfg_we    = 1'b0;
    cfg_stage = '0;
    cfg_sel   = '0;
    cfg_data  = '0;
    clr_state = 1'b0;
    test_reset();
    test_impulse();
    test_biquad();
    test_saturation();
    test_cfg_errors();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
